id_stage_pipe: RTL and testbench
================================

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 Parameter XLEN, default 32, data/PC width.
REQ-002 Parameter NUM_REGS, default 32, register count; RA_W = $clog2(NUM_REGS) is derived.
REQ-003 Parameter CTRL_WIDTH, default 24, width of the decoded control bundle.
REQ-004 Clk  in  1  clock; all state on rising edge.
REQ-005 Reset_n  in  1  reset, synchronous, active-low.
REQ-006 IF_Valid  in  1  fetch slot holds an instruction.
REQ-007 IF_Ready  out  1  ID accepts the fetch slot this cycle.
REQ-008 IF_PC  in  XLEN  PC of the fetch slot.
REQ-009 IF_Instruction  in  32  instruction word; rs1=[19:15], rs2=[24:20], rd=[11:7], low RA_W bits used.
REQ-010 Ctrl_in  in  CTRL_WIDTH  combinational decoder output for IF_Instruction.
REQ-011 Rs1_used, Rs2_used  in  1 each  decoder flags: the instruction reads rs1/rs2.
REQ-012 Flush  in  1  kill the ID slot and the fetch slot (taken branch/jump).
REQ-013 EX_Mem_rd_en  in  1  EX instruction is a load.
REQ-014 EX_Rd_addr  in  RA_W  EX destination.
REQ-015 WB_Rd_addr  in  RA_W, WB_Wr_data  in  XLEN, WB_Wr_en  in  1  register write port.
REQ-016 EX_Ready  in  1  EX accepts the ID slot.
REQ-017 ID_Valid  out  1  ID slot holds a live instruction.
REQ-018 ID_PC  out  XLEN, ID_Ctrl  out  CTRL_WIDTH, ID_Rs1_data/ID_Rs2_data  out  XLEN each, ID_Rs1_addr/ID_Rs2_addr/ID_Rd_addr  out  RA_W each  registered slot contents.
REQ-019 ID_Load_use_stall  out  1  combinational; hazard detected this cycle.

Function
REQ-020 Hazard = IF_Valid & EX_Mem_rd_en & (EX_Rd_addr!=0) & ((Rs1_used & rs1==EX_Rd_addr) | (Rs2_used & rs2==EX_Rd_addr)); drives ID_Load_use_stall.
REQ-021 IF_Ready = Flush | ((!ID_Valid | EX_Ready) & !Hazard).
REQ-022 Capture (IF_Valid & IF_Ready & !Flush): next cycle ID_Valid=1; PC, Ctrl_in, addresses and register-file read data are loaded; latency 1 cycle.
REQ-023 Drain without capture (EX_Ready, no capture): next cycle ID_Valid=0; ID_PC, ID_Ctrl and address outputs are 0 (bubble).
REQ-024 Hold (ID_Valid & !EX_Ready & !Flush): all outputs keep their values.
REQ-025 Hazard with EX_Ready inserts exactly one bubble per hazard cycle; the fetch slot is not consumed.
REQ-026 Flush has highest priority: next cycle ID_Valid=0 and the bubble values of REQ-023 apply; the fetch slot is consumed and dropped; Hazard is ignored.
REQ-027 Register file: NUM_REGS x XLEN; register 0 reads 0; writes to register 0 are ignored; a write takes effect at the clock edge.
REQ-028 The register-file read is combinational on IF_Instruction fields and is sampled only at capture.
REQ-029 ID_Rs1_data/ID_Rs2_data are not cleared by bubbles or flush; they are don't-care while ID_Valid=0.

Reset
REQ-030 While Reset_n=0 at an edge: ID_Valid=0; ID_PC, ID_Ctrl, all data and address outputs=0; all registers=0.
REQ-031 Reset overrides Flush, capture and WB writes in the same cycle.
REQ-032 IF_Ready=0 while Reset_n=0.

Configuration
REQ-033 Macro ID_BYPASS_EN.
REQ-034 Defined: at capture, WB_Wr_en & WB_Rd_addr!=0 & WB_Rd_addr==rs1/rs2 substitutes WB_Wr_data for that operand.
REQ-035 Defined: during hold, the same match updates the held ID_Rs1_data/ID_Rs2_data.
REQ-036 Undefined: captured and held data reflect register contents before the edge, and no substitution occurs.

Verification
REQ-037 Reset, then IF_Valid=1, PC=0x100, instruction ADD x3,x1,x2, EX_Ready=1 -> next cycle ID_Valid=1, ID_PC=0x100, ID_Rd_addr=3.
REQ-038 EX load to x5 (EX_Mem_rd_en=1, EX_Rd_addr=5); IF instruction reads rs1=x5 with Rs1_used=1 -> ID_Load_use_stall=1, IF_Ready=0, one bubble; capture on the next cycle once EX_Mem_rd_en=0.
REQ-039 Same as REQ-038 but with rs1=x0 and EX_Rd_addr=0 -> no stall.
REQ-040 EX_Ready=0 for 3 cycles with ID_Valid=1 -> outputs stable and IF_Ready=0; then Flush=1 -> next cycle ID_Valid=0, ID_Ctrl=0, and IF_Ready=1 during the Flush cycle.
REQ-041 WB writes x7=0xDEADBEEF in the capture cycle of an instruction reading x7 -> ID_Rs1_data=0xDEADBEEF with ID_BYPASS_EN defined, and the old value without it.
REQ-042 WB writes x0=0x1234, then read x0 -> ID_Rs1_data=0.

Source files
------------

// File: rtl/id_stage_pipe.sv
// Decode-stage pipeline register with register file, load-use hazard detection and flush.
// Optional WB-to-ID operand forwarding enabled by defining ID_BYPASS_EN.
module id_stage_pipe #(
    parameter  int unsigned XLEN       = 32,
    parameter  int unsigned NUM_REGS   = 32,
    parameter  int unsigned CTRL_WIDTH = 24,
    localparam int unsigned RA_W       = $clog2(NUM_REGS)
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  IF_Valid,
    output logic                  IF_Ready,
    input  logic [XLEN-1:0]       IF_PC,
    input  logic [31:0]           IF_Instruction,
    input  logic [CTRL_WIDTH-1:0] Ctrl_in,
    input  logic                  Rs1_used,
    input  logic                  Rs2_used,
    input  logic                  Flush,
    input  logic                  EX_Mem_rd_en,
    input  logic [RA_W-1:0]       EX_Rd_addr,
    input  logic [RA_W-1:0]       WB_Rd_addr,
    input  logic [XLEN-1:0]       WB_Wr_data,
    input  logic                  WB_Wr_en,
    input  logic                  EX_Ready,
    output logic                  ID_Valid,
    output logic [XLEN-1:0]       ID_PC,
    output logic [CTRL_WIDTH-1:0] ID_Ctrl,
    output logic [XLEN-1:0]       ID_Rs1_data,
    output logic [XLEN-1:0]       ID_Rs2_data,
    output logic [RA_W-1:0]       ID_Rs1_addr,
    output logic [RA_W-1:0]       ID_Rs2_addr,
    output logic [RA_W-1:0]       ID_Rd_addr,
    output logic                  ID_Load_use_stall
);

    typedef enum logic [1:0] {ACT_HOLD, ACT_CAPTURE, ACT_BUBBLE} slot_act_e;

    logic [XLEN-1:0]       rf_q [NUM_REGS];
    logic                  valid_q, valid_d;
    logic [XLEN-1:0]       pc_q, pc_d;
    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [XLEN-1:0]       rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
    logic [RA_W-1:0]       rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_addr_q, rd_addr_d;

    logic [RA_W-1:0] rs1_a, rs2_a, rd_a;
    logic [XLEN-1:0] rf_rs1, rf_rs2;
    logic            hazard, slot_free, capture;
    logic            instr_unused;
    slot_act_e       act;

    assign rs1_a        = IF_Instruction[15 +: RA_W];
    assign rs2_a        = IF_Instruction[20 +: RA_W];
    assign rd_a         = IF_Instruction[7 +: RA_W];
    assign instr_unused = ^IF_Instruction;

    assign rf_rs1 = (rs1_a == '0) ? '0 : rf_q[rs1_a];
    assign rf_rs2 = (rs2_a == '0) ? '0 : rf_q[rs2_a];

    assign hazard = IF_Valid & EX_Mem_rd_en & (EX_Rd_addr != '0) &
                    ((Rs1_used & (rs1_a == EX_Rd_addr)) | (Rs2_used & (rs2_a == EX_Rd_addr)));
    assign slot_free = ~valid_q | EX_Ready;
    assign IF_Ready  = Reset_n & (Flush | (slot_free & ~hazard));
    assign capture   = IF_Valid & IF_Ready & ~Flush;

    function automatic logic [XLEN-1:0] wb_fwd(input logic [RA_W-1:0] a, input logic [XLEN-1:0] d);
`ifdef ID_BYPASS_EN
        return (WB_Wr_en && WB_Rd_addr != '0 && WB_Rd_addr == a) ? WB_Wr_data : d;
`else
        return (a == a) ? d : d;
`endif
    endfunction

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        ctrl_d     = ctrl_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rd_addr_d  = rd_addr_q;

        // Flush dominates; a free slot with nothing captured becomes a bubble
        if (Flush || (!capture && slot_free)) act = ACT_BUBBLE;
        else if (capture)                     act = ACT_CAPTURE;
        else                                  act = ACT_HOLD;

        case (act)
            ACT_CAPTURE: begin
                valid_d    = 1'b1;
                pc_d       = IF_PC;
                ctrl_d     = Ctrl_in;
                rs1_addr_d = rs1_a;
                rs2_addr_d = rs2_a;
                rd_addr_d  = rd_a;
                rs1_data_d = wb_fwd(rs1_a, rf_rs1);
                rs2_data_d = wb_fwd(rs2_a, rf_rs2);
            end
            ACT_BUBBLE: begin
                valid_d    = 1'b0;
                pc_d       = '0;
                ctrl_d     = '0;
                rs1_addr_d = '0;
                rs2_addr_d = '0;
                rd_addr_d  = '0;
            end
            default: begin
                rs1_data_d = wb_fwd(rs1_addr_q, rs1_data_q);
                rs2_data_d = wb_fwd(rs2_addr_q, rs2_data_q);
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else if (WB_Wr_en && WB_Rd_addr != '0) begin
            rf_q[WB_Rd_addr] <= WB_Wr_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            ctrl_q     <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            ctrl_q     <= ctrl_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    assign ID_Valid          = valid_q;
    assign ID_PC             = pc_q;
    assign ID_Ctrl           = ctrl_q;
    assign ID_Rs1_data       = rs1_data_q;
    assign ID_Rs2_data       = rs2_data_q;
    assign ID_Rs1_addr       = rs1_addr_q;
    assign ID_Rs2_addr       = rs2_addr_q;
    assign ID_Rd_addr        = rd_addr_q;
    assign ID_Load_use_stall = hazard;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe; expectations follow ID_BYPASS_EN when defined.
module tb_id_stage_pipe;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        IF_Valid, IF_Ready;
    logic [31:0] IF_PC, IF_Instruction;
    logic [23:0] Ctrl_in;
    logic        Rs1_used, Rs2_used, Flush, EX_Mem_rd_en;
    logic [4:0]  EX_Rd_addr, WB_Rd_addr;
    logic [31:0] WB_Wr_data;
    logic        WB_Wr_en, EX_Ready;
    logic        ID_Valid;
    logic [31:0] ID_PC, ID_Rs1_data, ID_Rs2_data;
    logic [23:0] ID_Ctrl;
    logic [4:0]  ID_Rs1_addr, ID_Rs2_addr, ID_Rd_addr;
    logic        ID_Load_use_stall;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    id_stage_pipe #(.XLEN(32), .NUM_REGS(32), .CTRL_WIDTH(24)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .IF_Valid(IF_Valid), .IF_Ready(IF_Ready),
        .IF_PC(IF_PC), .IF_Instruction(IF_Instruction), .Ctrl_in(Ctrl_in),
        .Rs1_used(Rs1_used), .Rs2_used(Rs2_used), .Flush(Flush),
        .EX_Mem_rd_en(EX_Mem_rd_en), .EX_Rd_addr(EX_Rd_addr),
        .WB_Rd_addr(WB_Rd_addr), .WB_Wr_data(WB_Wr_data), .WB_Wr_en(WB_Wr_en),
        .EX_Ready(EX_Ready), .ID_Valid(ID_Valid), .ID_PC(ID_PC), .ID_Ctrl(ID_Ctrl),
        .ID_Rs1_data(ID_Rs1_data), .ID_Rs2_data(ID_Rs2_data),
        .ID_Rs1_addr(ID_Rs1_addr), .ID_Rs2_addr(ID_Rs2_addr), .ID_Rd_addr(ID_Rd_addr),
        .ID_Load_use_stall(ID_Load_use_stall)
    );

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b0, rd, 7'h33};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        WB_Wr_en = 1'b1; WB_Rd_addr = a; WB_Wr_data = d;
        tick();
        WB_Wr_en = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] instr, input logic [23:0] ctrl);
        IF_Valid = 1'b1; IF_PC = pc; IF_Instruction = instr; Ctrl_in = ctrl;
    endtask

    initial begin
        Reset_n = 1'b0; IF_Valid = 1'b1; IF_PC = 32'h40; IF_Instruction = rtype(5'd1, 5'd1, 5'd1);
        Ctrl_in = 24'h1; Rs1_used = 1'b1; Rs2_used = 1'b1; Flush = 1'b0;
        EX_Mem_rd_en = 1'b0; EX_Rd_addr = '0; WB_Rd_addr = '0; WB_Wr_data = '0;
        WB_Wr_en = 1'b0; EX_Ready = 1'b1;
        tick(); tick();
        check("rst_valid", ID_Valid, 0);
        check("rst_pc", ID_PC, 0);
        check("rst_ctrl", ID_Ctrl, 0);
        check("rst_rd", ID_Rd_addr, 0);
        check("rst_if_ready", IF_Ready, 0);

        Reset_n = 1'b1; IF_Valid = 1'b0;
        wb_write(5'd1, 32'h11);
        wb_write(5'd2, 32'h22);
        wb_write(5'd5, 32'h55);
        wb_write(5'd7, 32'h77);

        // basic capture
        fetch(32'h100, rtype(5'd3, 5'd1, 5'd2), 24'hABCDE);
        #1 check("cap_if_ready", IF_Ready, 1);
        tick();
        check("cap_valid", ID_Valid, 1);
        check("cap_pc", ID_PC, 32'h100);
        check("cap_rd", ID_Rd_addr, 3);
        check("cap_rs1a", ID_Rs1_addr, 1);
        check("cap_rs2a", ID_Rs2_addr, 2);
        check("cap_rs1d", ID_Rs1_data, 32'h11);
        check("cap_rs2d", ID_Rs2_data, 32'h22);
        check("cap_ctrl", ID_Ctrl, 24'hABCDE);

        // drain to bubble
        IF_Valid = 1'b0;
        tick();
        check("drain_valid", ID_Valid, 0);
        check("drain_pc", ID_PC, 0);
        check("drain_ctrl", ID_Ctrl, 0);
        check("drain_rd", ID_Rd_addr, 0);

        // load-use on rs1
        EX_Mem_rd_en = 1'b1; EX_Rd_addr = 5'd5;
        fetch(32'h104, rtype(5'd6, 5'd5, 5'd2), 24'h104);
        #1 check("lu_stall", ID_Load_use_stall, 1);
        check("lu_if_ready", IF_Ready, 0);
        tick();
        check("lu_bubble", ID_Valid, 0);
        EX_Mem_rd_en = 1'b0;
        #1 check("lu_clear_stall", ID_Load_use_stall, 0);
        check("lu_clear_ready", IF_Ready, 1);
        tick();
        check("lu_cap_valid", ID_Valid, 1);
        check("lu_cap_pc", ID_PC, 32'h104);
        check("lu_cap_rs1d", ID_Rs1_data, 32'h55);

        // load-use on rs2, and rs2 not used
        EX_Mem_rd_en = 1'b1; EX_Rd_addr = 5'd2;
        fetch(32'h108, rtype(5'd6, 5'd5, 5'd2), 24'h108);
        #1 check("lu2_stall", ID_Load_use_stall, 1);
        tick();
        check("lu2_bubble", ID_Valid, 0);
        Rs2_used = 1'b0;
        #1 check("lu2_unused_stall", ID_Load_use_stall, 0);
        Rs2_used = 1'b1;

        // x0 never hazards
        EX_Rd_addr = 5'd0;
        fetch(32'h108, rtype(5'd4, 5'd0, 5'd0), 24'h108);
        #1 check("x0_stall", ID_Load_use_stall, 0);
        check("x0_if_ready", IF_Ready, 1);
        tick();
        check("x0_cap_pc", ID_PC, 32'h108);
        check("x0_cap_rs1d", ID_Rs1_data, 0);

        // hold for three cycles
        EX_Mem_rd_en = 1'b0; EX_Ready = 1'b0;
        fetch(32'h10C, rtype(5'd9, 5'd3, 5'd1), 24'h10C);
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_if_ready", IF_Ready, 0);
            tick();
            check("hold_valid", ID_Valid, 1);
            check("hold_pc", ID_PC, 32'h108);
            check("hold_ctrl", ID_Ctrl, 24'h108);
        end

        // flush beats a simultaneous hazard
        Flush = 1'b1; EX_Mem_rd_en = 1'b1; EX_Rd_addr = 5'd3;
        #1 check("fl_stall", ID_Load_use_stall, 1);
        check("fl_if_ready", IF_Ready, 1);
        tick();
        check("fl_valid", ID_Valid, 0);
        check("fl_ctrl", ID_Ctrl, 0);
        check("fl_pc", ID_PC, 0);
        Flush = 1'b0; EX_Mem_rd_en = 1'b0; EX_Ready = 1'b1;

        // WB write in the capture cycle
        fetch(32'h110, rtype(5'd8, 5'd7, 5'd1), 24'h110);
        wb_write(5'd7, 32'hDEADBEEF);
`ifdef ID_BYPASS_EN
        check("wb_cap_rs1d", ID_Rs1_data, 32'hDEADBEEF);
`else
        check("wb_cap_rs1d", ID_Rs1_data, 32'h77);
`endif
        check("wb_cap_rs2d", ID_Rs2_data, 32'h11);
        fetch(32'h114, rtype(5'd8, 5'd7, 5'd1), 24'h114);
        tick();
        check("wb_after_rs1d", ID_Rs1_data, 32'hDEADBEEF);

        // WB write while holding
        IF_Valid = 1'b0; EX_Ready = 1'b0;
        wb_write(5'd1, 32'h99);
        check("hold_wb_pc", ID_PC, 32'h114);
`ifdef ID_BYPASS_EN
        check("hold_wb_rs2d", ID_Rs2_data, 32'h99);
`else
        check("hold_wb_rs2d", ID_Rs2_data, 32'h11);
`endif
        EX_Ready = 1'b1;

        // writes to x0 are ignored
        wb_write(5'd0, 32'h1234);
        fetch(32'h118, rtype(5'd10, 5'd0, 5'd1), 24'h118);
        tick();
        check("x0w_rs1d", ID_Rs1_data, 0);
        check("x0w_rs2d", ID_Rs2_data, 32'h99);

        // reset overrides capture and WB write
        Reset_n = 1'b0;
        fetch(32'h11C, rtype(5'd11, 5'd2, 5'd1), 24'h11C);
        #1 check("rst2_if_ready", IF_Ready, 0);
        wb_write(5'd2, 32'hFF);
        check("rst2_valid", ID_Valid, 0);
        check("rst2_pc", ID_PC, 0);
        check("rst2_rs1d", ID_Rs1_data, 0);
        Reset_n = 1'b1;
        fetch(32'h200, rtype(5'd12, 5'd2, 5'd1), 24'h200);
        tick();
        check("rst2_cap_valid", ID_Valid, 1);
        check("rst2_cap_rd", ID_Rd_addr, 12);
        check("rst2_cap_rs1d", ID_Rs1_data, 0);
        check("rst2_cap_rs2d", ID_Rs2_data, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
